// File: rtl/seq_bit_gen.sv
// seq_bit_gen: serial pattern transmitter, MSB-first, repeated `count` times with `gap` idle cycles.
// Optional even-parity bit per repetition when SEQ_GEN_PARITY_EN is defined.
module seq_bit_gen #(
    parameter int PATTERN_W = 4,
    parameter int CNT_W     = 8,
    parameter int GAP_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [CNT_W-1:0]     count,
    input  logic [GAP_W-1:0]     gap,
    output logic                 bout,
    output logic                 bvalid,
    output logic                 frame_end,
    output logic                 busy,
    output logic                 done
);
    localparam int IDX_W = $clog2(PATTERN_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PATTERN_W - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, GAP, PAR, DONE} state_t;

    state_t                 r_state, w_nstate;
    logic [IDX_W-1:0]       r_idx, w_nidx;
    logic [CNT_W-1:0]       r_reps, w_nreps;
    logic [GAP_W-1:0]       r_gcnt, w_ngcnt, r_gap, w_ngap;
    logic [PATTERN_W-1:0]   r_pat, w_npat;
    logic                   w_last;
    logic                   w_nbout, w_nbvalid, w_nfe, w_nbusy, w_ndone;

    always_comb begin
        w_nstate = r_state;
        w_nidx   = r_idx;
        w_nreps  = r_reps;
        w_ngcnt  = r_gcnt;
        w_npat   = r_pat;
        w_ngap   = r_gap;
        w_last   = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_npat   = pattern;
                w_nreps  = count;
                w_ngap   = gap;
                w_nidx   = IDX_TOP;
                w_nstate = (count == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                w_nidx = r_idx - 1'b1;
`ifdef SEQ_GEN_PARITY_EN
                if (r_idx == '0) w_nstate = PAR;
`else
                w_last = (r_idx == '0);
`endif
            end
`ifdef SEQ_GEN_PARITY_EN
            PAR:  w_last = 1'b1;
`endif
            GAP: begin
                w_ngcnt = r_gcnt - 1'b1;
                if (r_gcnt == GAP_W'(1)) begin
                    w_nstate = SHIFT;
                    w_nidx   = IDX_TOP;
                end
            end
            DONE:    w_nstate = IDLE;
            default: w_nstate = IDLE;
        endcase
        // end of a repetition: either finish, restart immediately, or idle for gap cycles
        if (w_last) begin
            w_nreps  = r_reps - 1'b1;
            w_nidx   = IDX_TOP;
            w_ngcnt  = r_gap;
            w_nstate = (r_reps == CNT_W'(1)) ? DONE : (r_gap == '0) ? SHIFT : GAP;
        end
        // outputs are computed from the next state so they can be registered
`ifdef SEQ_GEN_PARITY_EN
        w_nbvalid = (w_nstate == SHIFT) || (w_nstate == PAR);
        w_nbout   = (w_nstate == SHIFT) ? w_npat[w_nidx] : (w_nstate == PAR) ? ^w_npat : 1'b0;
        w_nfe     = (w_nstate == PAR);
        w_nbusy   = (w_nstate == SHIFT) || (w_nstate == GAP) || (w_nstate == PAR);
`else
        w_nbvalid = (w_nstate == SHIFT);
        w_nbout   = (w_nstate == SHIFT) ? w_npat[w_nidx] : 1'b0;
        w_nfe     = (w_nstate == SHIFT) && (w_nidx == '0);
        w_nbusy   = (w_nstate == SHIFT) || (w_nstate == GAP);
`endif
        w_ndone   = (w_nstate == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_reps    <= '0;
            r_gcnt    <= '0;
            r_gap     <= '0;
            r_pat     <= '0;
            bout      <= 1'b0;
            bvalid    <= 1'b0;
            frame_end <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_idx     <= w_nidx;
            r_reps    <= w_nreps;
            r_gcnt    <= w_ngcnt;
            r_gap     <= w_ngap;
            r_pat     <= w_npat;
            bout      <= w_nbout;
            bvalid    <= w_nbvalid;
            frame_end <= w_nfe;
            busy      <= w_nbusy;
            done      <= w_ndone;
        end
    end
endmodule

// File: tb/tb_seq_bit_gen.sv
// tb_seq_bit_gen: directed checks of seq_bit_gen; each cycle compares {bvalid,bout,frame_end,busy,done}.
module tb_seq_bit_gen;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [3:0] pattern;
    logic [7:0] count;
    logic [3:0] gap;
    logic       bout, bvalid, frame_end, busy, done;
    int         total = 0;
    int         bad = 0;
    logic [4:0] exp_q[$];

    localparam logic [4:0] B1 = 5'b11010, B0 = 5'b10010, E1 = 5'b11110, E0 = 5'b10110,
                           GP = 5'b00010, DN = 5'b00001, ID = 5'b00000;

    seq_bit_gen dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .count(count), .gap(gap),
        .bout(bout), .bvalid(bvalid), .frame_end(frame_end), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int cyc, input logic [4:0] expv);
        logic [4:0] obs;
        obs = {bvalid, bout, frame_end, busy, done};
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cycle %0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic go(input logic [3:0] p, input logic [7:0] c, input logic [3:0] g);
        pattern = p;
        count   = c;
        gap     = g;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic expect_seq(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i != 0) tick();
            check(tag, i + 1, exp_q[i]);
        end
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pattern = '0; count = '0; gap = '0;
        tick();
        tick();
        check("reset", 0, ID);
        reset = 1'b0;
        tick();
        check("idle", 0, ID);

        go(4'b1001, 8'd1, 4'd0);
        exp_q = '{B1, B0, B0, E1, DN, ID};
        expect_seq("t1_single");

        go(4'b1001, 8'd3, 4'd2);
        pattern = 4'b0110; count = 8'd9; gap = 4'd0;
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(B1); exp_q.push_back(B0); exp_q.push_back(B0); exp_q.push_back(E1);
            if (r < 2) begin exp_q.push_back(GP); exp_q.push_back(GP); end
        end
        exp_q.push_back(DN);
        exp_q.push_back(ID);
        expect_seq("t2_gap");

        go(4'b1111, 8'd0, 4'd3);
        exp_q = '{DN, ID, ID};
        expect_seq("t3_zero");

        pattern = 4'b1001; count = 8'd2; gap = 4'd0; start = 1'b1;
        tick();
        exp_q = '{B1, B0, B0, E1, B1, B0, B0, E1, DN, ID, B1};
        expect_seq("t4_held");
        start = 1'b0;
        exp_q = '{B0, B0, E1, B1, B0, B0, E1, DN, ID};
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            check("t4_second", 12 + i, exp_q[i]);
        end
        exp_q.delete();

        go(4'b1001, 8'd2, 4'd0);
        exp_q = '{B1, B0, B0};
        expect_seq("t5_pre");
        reset = 1'b1;
        tick();
        check("t5_abort", 4, ID);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_nodone", 5 + i, ID);
        end

        go(4'b1011, 8'd1, 4'd0);
`ifdef SEQ_GEN_PARITY_EN
        exp_q = '{B1, B0, B1, B1, E1, DN, ID};
`else
        exp_q = '{B1, B0, B1, E1, DN, ID};
`endif
        expect_seq("t6_frame");

        go(4'b0110, 8'd2, 4'd1);
`ifdef SEQ_GEN_PARITY_EN
        exp_q = '{B0, B1, B1, B0, E0, GP, B0, B1, B1, B0, E0, DN, ID};
`else
        exp_q = '{B0, B1, B1, E0, GP, B0, B1, B1, E0, DN, ID};
`endif
        expect_seq("t7_gap1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
